genius_rodada_n: RTL and testbench
==================================

Name: genius_rodada_n

Overview:
Parametrised round engine for the memory (Genius) game with the "player appends" mode built in.
- Round r replays the r stored plays on the LEDs.
- The player then repeats those r plays and enters one new play, which is written into internal memory.
- Generalises button count, sequence depth and all timings; adds one-hot input validation, a skip-replay mode and a victory condition.
- Sits between the button/LED pins and the top-level game controller, which only starts games and reads the result flags.

Parameters:
NBOT, 4, number of buttons/LEDs (one-hot play width)
DEPTH, 16, maximum sequence length (memory words); AW = $clog2(DEPTH) derived localparam
T_MOSTRA, 10000, cycles each stored play is lit during replay
T_PAUSA, 2500, cycles LEDs are dark after each replayed play and before each replay phase
T_FEEDBACK, 2500, cycles the player's accepted play is echoed on LEDs
T_TIMEOUT, 25000, cycles allowed between plays in the wait phase

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iniciar  in  1  start a new game; honoured only in OCIOSO or a FIM_* state
mostra_en  in  1  1 = replay stored sequence each round; 0 = skip replay (hard mode); sampled on iniciar
botoes  in  NBOT  raw button levels
leds  out  NBOT  LED drive
rodada  out  AW  current round index (0-based)
pronto  out  1  level, 1 in any FIM_* state
acertou  out  1  level, 1 in FIM_VITORIA
errou  out  1  level, 1 in FIM_ERRO
timeout  out  1  level, 1 in FIM_TIMEOUT
db_estado  out  4  state encoding for debug

Behaviour:
- Reset: state OCIOSO; leds=0, rodada=0, endereco=0, all flags 0, timer 0, edge register 0. Memory contents are not cleared; they are don't-care because the game never reads an unwritten word.
- Edge detection: tem = |botoes; prev registers tem every cycle. jogada = tem & ~prev, acted on only in ESPERA. A button held across a state change never fires twice.
- OCIOSO / FIM_*:
  - iniciar=1 latches mostra_en, clears rodada, endereco, timer and flags.
  - Next state is ESPERA, because round 0 has nothing to replay.
- PAUSA:
  - leds=0 for T_PAUSA cycles, then MOSTRA with endereco=0.
  - If mostra_en=0, PAUSA goes straight to ESPERA.
- MOSTRA:
  - leds=mem[endereco] for T_MOSTRA cycles, then GAP (leds=0, T_PAUSA cycles).
  - After GAP: if endereco==rodada-1, go to ESPERA with endereco=0; else endereco+1 and back to MOSTRA.
- ESPERA:
  - leds=0; timer counts from 0.
  - On the jogada cycle, botoes is captured into jog_reg.
  - Valid = popcount(botoes)==1.
  - If endereco<rodada: correct = valid && botoes==mem[endereco].
  - If endereco==rodada: correct = valid, and mem[endereco]<=botoes is written in that same cycle.
  - Correct goes to FEEDBACK; otherwise FIM_ERRO.
  - Timer reaching T_TIMEOUT-1 with no jogada goes to FIM_TIMEOUT.
  - If jogada and timeout occur in the same cycle, jogada wins.
- FEEDBACK:
  - leds=jog_reg for T_FEEDBACK cycles; timer is zeroed on entry.
  - Then, if endereco<rodada: endereco+1, back to ESPERA.
  - Otherwise the round is complete. If rodada==DEPTH-1, go to FIM_VITORIA; else rodada+1, endereco=0, go to PAUSA.
- Latency:
  - Button rising edge at cycle k: state is FEEDBACK and leds==jog_reg from cycle k+1.
  - FIM_ERRO and the pronto/errou flags also appear at cycle k+1.
- FIM_* states hold leds=0 and their flags until iniciar or reset.
- iniciar in any non-terminal state is ignored.
- reset mid-operation: returns to OCIOSO in the next cycle regardless of state; no memory write occurs in the reset cycle.
- Timer widths: $clog2 of the largest T_* + 1. All counters wrap-free by construction.

Decomposition:
- Package genius_pkg:
  - state encodings OCIOSO, PAUSA, MOSTRA, GAP, ESPERA, FEEDBACK, FIM_ERRO, FIM_TIMEOUT, FIM_VITORIA (4-bit);
  - default timing constants;
  - a one-hot check function.
- Sub-module temporizador_ciclos:
  - parameter MAX; inputs zera (synchronous), conta; output fim.
  - One instance, with MAX selected by state.
- Memory is an inferred DEPTH×NBOT register array with a synchronous write and a combinational read.

Test Plan:
Bench parameters: NBOT=4, DEPTH=4, T_MOSTRA=4, T_PAUSA=2, T_FEEDBACK=3, T_TIMEOUT=8.
- Reset, then iniciar (mostra_en=1), press 0100 -> leds=0100 for 3 cycles; rodada=1; PAUSA 2 cycles; MOSTRA shows 0100 for 4 cycles then 2 dark cycles; state ESPERA.
- Round 1: press 0100, then 0001 -> both echoed; rodada=2; replay shows 0100 then 0001 with correct T_MOSTRA/T_PAUSA spacing.
- Round 1: press 1000 when 0100 is expected -> next cycle errou=1, pronto=1, leds=0; iniciar then restarts with rodada=0.
- ESPERA with no press for 8 cycles -> timeout=1, pronto=1. Separately, a press landing on the 8th cycle -> FEEDBACK, no timeout.
- Press 0110 as the new play -> FIM_ERRO and no memory write (checked by replay in a following game that rewrites the word). Holding a button from FEEDBACK into ESPERA -> no second play.
- mostra_en=0, complete 4 rounds -> no replay phases; after round 3 feedback, acertou=1, pronto=1, rodada=3. Reset asserted during MOSTRA -> OCIOSO, leds=0 next cycle.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius round engine.
// Holds the state encoding, the default timings and small helper functions.
package genius_pkg;

   typedef enum logic [3:0] {
      OCIOSO      = 4'd0,
      PAUSA       = 4'd1,
      MOSTRA      = 4'd2,
      GAP         = 4'd3,
      ESPERA      = 4'd4,
      FEEDBACK    = 4'd5,
      FIM_ERRO    = 4'd6,
      FIM_TIMEOUT = 4'd7,
      FIM_VITORIA = 4'd8
   } estado_t;

   localparam int DEF_T_MOSTRA   = 10000;
   localparam int DEF_T_PAUSA    = 2500;
   localparam int DEF_T_FEEDBACK = 2500;
   localparam int DEF_T_TIMEOUT  = 25000;

   // A play is legal only when exactly one button is down.
   function automatic logic eh_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// Cycle counter shared by every timed state of the round engine.
// fim rises on the last cycle of a window of 'limite' cycles; zera restarts it.
module temporizador_ciclos #(
   parameter int MAX = 25000,
   localparam int W  = $clog2(MAX + 1)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   input  logic [W-1:0] limite,
   output logic         fim
);

   logic [W-1:0] cnt;

   assign fim = conta && (cnt == (limite - 1'b1));

   // Holds at the terminal value so it can never wrap.
   always_ff @(posedge clock) begin
      if (reset || zera) begin
         cnt <= '0;
      end else if (conta && !fim) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/genius_rodada_n.sv
// Round engine for the memory game: replays stored plays, checks the player's
// repetition and appends the player's new play to the sequence memory.
module genius_rodada_n
   import genius_pkg::*;
#(
   parameter int NBOT       = 4,
   parameter int DEPTH      = 16,
   parameter int T_MOSTRA   = DEF_T_MOSTRA,
   parameter int T_PAUSA    = DEF_T_PAUSA,
   parameter int T_FEEDBACK = DEF_T_FEEDBACK,
   parameter int T_TIMEOUT  = DEF_T_TIMEOUT,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            iniciar,
   input  logic            mostra_en,
   input  logic [NBOT-1:0] botoes,
   output logic [NBOT-1:0] leds,
   output logic [AW-1:0]   rodada,
   output logic            pronto,
   output logic            acertou,
   output logic            errou,
   output logic            timeout,
   output logic [3:0]      db_estado
);

   localparam int T_MAX = max_int(max_int(T_MOSTRA, T_PAUSA), max_int(T_FEEDBACK, T_TIMEOUT));
   localparam int TW    = $clog2(T_MAX + 1);

   estado_t         state, state_next;
   logic [AW-1:0]   endereco;
   logic            mostra_q;
   logic [NBOT-1:0] jog_reg;
   logic            prev;
   logic [NBOT-1:0] mem [DEPTH];
   logic [NBOT-1:0] mem_rd;
   logic            tem, jogada, valida, correta, nova, ultima, mem_we;
   logic            fim, zera, conta;
   logic [TW-1:0]   limite;

   assign tem    = |botoes;
   assign jogada = tem && !prev;
   assign valida = eh_one_hot(32'(botoes));
   assign mem_rd = mem[endereco];
   assign nova   = (endereco == rodada);
   assign ultima = (rodada == AW'(DEPTH - 1));
   assign correta = nova ? valida : (valida && (botoes == mem_rd));
   assign mem_we = !reset && (state == ESPERA) && jogada && nova && valida;

   // Every state change restarts the shared timer from zero.
   assign zera  = (state_next != state);
   assign conta = (state == PAUSA) || (state == MOSTRA) || (state == GAP) ||
                  (state == ESPERA) || (state == FEEDBACK);

   always_comb begin
      limite = TW'(T_TIMEOUT);
      case (state)
         PAUSA, GAP: limite = TW'(T_PAUSA);
         MOSTRA:     limite = TW'(T_MOSTRA);
         FEEDBACK:   limite = TW'(T_FEEDBACK);
         default:    limite = TW'(T_TIMEOUT);
      endcase
   end

   temporizador_ciclos #(.MAX(T_MAX)) u_timer (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera),
      .conta  (conta),
      .limite (limite),
      .fim    (fim)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= OCIOSO;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         OCIOSO, FIM_ERRO, FIM_TIMEOUT, FIM_VITORIA:
            if (iniciar) state_next = ESPERA;
         PAUSA:
            if (!mostra_q)  state_next = ESPERA;
            else if (fim)   state_next = MOSTRA;
         MOSTRA:
            if (fim) state_next = GAP;
         GAP:
            if (fim) state_next = (endereco == rodada - 1'b1) ? ESPERA : MOSTRA;
         // A play on the last timeout cycle still counts as a play.
         ESPERA:
            if (jogada)   state_next = correta ? FEEDBACK : FIM_ERRO;
            else if (fim) state_next = FIM_TIMEOUT;
         FEEDBACK:
            if (fim) begin
               if (!nova)      state_next = ESPERA;
               else if (ultima) state_next = FIM_VITORIA;
               else            state_next = PAUSA;
            end
         default: state_next = OCIOSO;
      endcase
   end

   always_comb begin
      leds      = '0;
      pronto    = (state == FIM_ERRO) || (state == FIM_TIMEOUT) || (state == FIM_VITORIA);
      acertou   = (state == FIM_VITORIA);
      errou     = (state == FIM_ERRO);
      timeout   = (state == FIM_TIMEOUT);
      db_estado = state;
      if (state == MOSTRA)   leds = mem_rd;
      if (state == FEEDBACK) leds = jog_reg;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rodada   <= '0;
         endereco <= '0;
         mostra_q <= 1'b0;
         jog_reg  <= '0;
         prev     <= 1'b0;
      end else begin
         prev <= tem;
         case (state)
            OCIOSO, FIM_ERRO, FIM_TIMEOUT, FIM_VITORIA:
               if (iniciar) begin
                  mostra_q <= mostra_en;
                  rodada   <= '0;
                  endereco <= '0;
               end
            PAUSA:
               endereco <= '0;
            GAP:
               if (fim) endereco <= (endereco == rodada - 1'b1) ? '0 : endereco + 1'b1;
            ESPERA:
               if (jogada) jog_reg <= botoes;
            FEEDBACK:
               if (fim) begin
                  if (!nova) begin
                     endereco <= endereco + 1'b1;
                  end else if (!ultima) begin
                     rodada   <= rodada + 1'b1;
                     endereco <= '0;
                  end
               end
            default: ;
         endcase
      end
   end

   // Sequence memory: no reset, written only with a new valid play.
   always_ff @(posedge clock) begin
      if (mem_we) mem[endereco] <= botoes;
   end

endmodule

// File: tb/tb_genius_rodada_n.sv
// Directed bench for genius_rodada_n: cycle-exact vector table for the
// replay/feedback/error/timeout paths, then a hard-mode game to victory.
module tb_genius_rodada_n;

   localparam logic [3:0] S_O  = 4'd0, S_P  = 4'd1, S_M  = 4'd2, S_G  = 4'd3,
                          S_E  = 4'd4, S_F  = 4'd5, S_FE = 4'd6, S_FT = 4'd7,
                          S_FV = 4'd8;

   logic       clock = 1'b0;
   logic       reset, iniciar, mostra_en;
   logic [3:0] botoes, leds, db_estado;
   logic [1:0] rodada;
   logic       pronto, acertou, errou, timeout;

   int n_chk = 0;
   int n_err = 0;
   logic saw_replay = 1'b0;

   typedef struct {
      logic       ini;
      logic       me;
      logic       rst;
      logic [3:0] bot;
      logic [3:0] st;
      logic [3:0] lds;
      logic [1:0] rod;
   } vec_t;

   vec_t vq[$];

   genius_rodada_n #(
      .NBOT(4), .DEPTH(4), .T_MOSTRA(4), .T_PAUSA(2), .T_FEEDBACK(3), .T_TIMEOUT(8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .mostra_en (mostra_en),
      .botoes    (botoes),
      .leds      (leds),
      .rodada    (rodada),
      .pronto    (pronto),
      .acertou   (acertou),
      .errou     (errou),
      .timeout   (timeout),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
      end
   endtask

   // Flags {pronto, acertou, errou, timeout} implied by a state.
   function automatic logic [3:0] flags_of(input logic [3:0] st);
      return {(st == S_FE) || (st == S_FT) || (st == S_FV), st == S_FV, st == S_FE, st == S_FT};
   endfunction

   task automatic add(input logic i, input logic r, input logic [3:0] b,
                      input logic [3:0] st, input logic [3:0] l, input logic [1:0] rd);
      vq.push_back('{i, 1'b1, r, b, st, l, rd});
   endtask

   task automatic addn(input int n, input logic [3:0] b, input logic [3:0] st,
                       input logic [3:0] l, input logic [1:0] rd);
      for (int k = 0; k < n; k++) add(1'b0, 1'b0, b, st, l, rd);
   endtask

   task automatic wait_state(input logic [3:0] target, input int budget, input int id);
      int n = 0;
      while (db_estado != target && n < budget) begin
         tick();
         if (db_estado == S_M || db_estado == S_G) saw_replay = 1'b1;
         n++;
      end
      chk("wait_state", id, db_estado, target);
   endtask

   initial begin
      logic [3:0] seq [4];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;

      // Round 0: start, new play 0100, replay of one play.
      add(1'b1, 1'b0, 4'b0000, S_E, 4'b0000, 2'd0);
      add(1'b0, 1'b0, 4'b0100, S_F, 4'b0100, 2'd0);
      add(1'b0, 1'b0, 4'b0100, S_F, 4'b0100, 2'd0);
      add(1'b0, 1'b0, 4'b0000, S_F, 4'b0100, 2'd0);
      addn(2, 4'b0000, S_P, 4'b0000, 2'd1);
      addn(4, 4'b0000, S_M, 4'b0100, 2'd1);
      addn(2, 4'b0000, S_G, 4'b0000, 2'd1);
      add(1'b0, 1'b0, 4'b0000, S_E, 4'b0000, 2'd1);
      // Round 1: repeat 0100 held into ESPERA, then new play 0001.
      addn(3, 4'b0100, S_F, 4'b0100, 2'd1);
      addn(2, 4'b0100, S_E, 4'b0000, 2'd1);
      add(1'b0, 1'b0, 4'b0000, S_E, 4'b0000, 2'd1);
      add(1'b0, 1'b0, 4'b0001, S_F, 4'b0001, 2'd1);
      addn(2, 4'b0000, S_F, 4'b0001, 2'd1);
      addn(2, 4'b0000, S_P, 4'b0000, 2'd2);
      addn(2, 4'b0000, S_M, 4'b0100, 2'd2);
      add(1'b1, 1'b0, 4'b0000, S_M, 4'b0100, 2'd2);
      addn(1, 4'b0000, S_M, 4'b0100, 2'd2);
      addn(2, 4'b0000, S_G, 4'b0000, 2'd2);
      addn(4, 4'b0000, S_M, 4'b0001, 2'd2);
      addn(2, 4'b0000, S_G, 4'b0000, 2'd2);
      add(1'b0, 1'b0, 4'b0000, S_E, 4'b0000, 2'd2);
      // Round 2: wrong button.
      add(1'b0, 1'b0, 4'b1000, S_FE, 4'b0000, 2'd2);
      add(1'b0, 1'b0, 4'b0000, S_FE, 4'b0000, 2'd2);
      // Restart, then let ESPERA time out.
      add(1'b1, 1'b0, 4'b0000, S_E, 4'b0000, 2'd0);
      addn(7, 4'b0000, S_E, 4'b0000, 2'd0);
      addn(2, 4'b0000, S_FT, 4'b0000, 2'd0);
      // Restart, press on the last timeout cycle: play wins and rewrites word 0.
      add(1'b1, 1'b0, 4'b0000, S_E, 4'b0000, 2'd0);
      addn(7, 4'b0000, S_E, 4'b0000, 2'd0);
      add(1'b0, 1'b0, 4'b1000, S_F, 4'b1000, 2'd0);
      addn(2, 4'b0000, S_F, 4'b1000, 2'd0);
      addn(2, 4'b0000, S_P, 4'b0000, 2'd1);
      addn(4, 4'b0000, S_M, 4'b1000, 2'd1);
      addn(2, 4'b0000, S_G, 4'b0000, 2'd1);
      add(1'b0, 1'b0, 4'b0000, S_E, 4'b0000, 2'd1);
      // Round 1: correct repeat, then a two-button new play.
      add(1'b0, 1'b0, 4'b1000, S_F, 4'b1000, 2'd1);
      addn(2, 4'b0000, S_F, 4'b1000, 2'd1);
      add(1'b0, 1'b0, 4'b0000, S_E, 4'b0000, 2'd1);
      add(1'b0, 1'b0, 4'b0110, S_FE, 4'b0000, 2'd1);
      add(1'b0, 1'b0, 4'b0000, S_FE, 4'b0000, 2'd1);
      // New game rewrites word 0; reset lands during its replay.
      add(1'b1, 1'b0, 4'b0000, S_E, 4'b0000, 2'd0);
      add(1'b0, 1'b0, 4'b0010, S_F, 4'b0010, 2'd0);
      addn(2, 4'b0000, S_F, 4'b0010, 2'd0);
      addn(2, 4'b0000, S_P, 4'b0000, 2'd1);
      addn(2, 4'b0000, S_M, 4'b0010, 2'd1);
      add(1'b0, 1'b1, 4'b0000, S_O, 4'b0000, 2'd0);
      add(1'b0, 1'b0, 4'b0000, S_O, 4'b0000, 2'd0);

      reset = 1'b1; iniciar = 1'b0; mostra_en = 1'b1; botoes = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_estado", -1, db_estado, S_O);
      chk("reset_leds",   -1, leds, 4'b0000);
      chk("reset_rodada", -1, rodada, 2'd0);
      chk("reset_flags",  -1, {pronto, acertou, errou, timeout}, 4'b0000);

      for (int i = 0; i < vq.size(); i++) begin
         iniciar   = vq[i].ini;
         mostra_en = vq[i].me;
         reset     = vq[i].rst;
         botoes    = vq[i].bot;
         tick();
         chk("estado", i, db_estado, vq[i].st);
         chk("leds",   i, leds, vq[i].lds);
         chk("rodada", i, rodada, vq[i].rod);
         chk("flags",  i, {pronto, acertou, errou, timeout}, flags_of(vq[i].st));
      end
      iniciar = 1'b0; reset = 1'b0; botoes = '0;

      // Hard mode: no replay, four full rounds to victory.
      iniciar = 1'b1; mostra_en = 1'b0;
      tick();
      iniciar = 1'b0; mostra_en = 1'b1;
      chk("hard_start", 1000, db_estado, S_E);
      for (int r = 0; r < 4; r++) begin
         for (int e = 0; e <= r; e++) begin
            wait_state(S_E, 20, 1100 + r * 10 + e);
            botoes = seq[e];
            tick();
            botoes = '0;
            chk("hard_estado", 1200 + r * 10 + e, db_estado, S_F);
            chk("hard_leds",   1200 + r * 10 + e, leds, seq[e]);
         end
      end
      wait_state(S_FV, 20, 1300);
      chk("vitoria_flags",  1301, {pronto, acertou, errou, timeout}, 4'b1100);
      chk("vitoria_rodada", 1302, rodada, 2'd3);
      chk("vitoria_leds",   1303, leds, 4'b0000);
      chk("no_replay",      1304, saw_replay, 1'b0);
      tick();
      chk("vitoria_hold",   1305, db_estado, S_FV);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
